keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x3 matrix keypad column scanner with
// press/release debounce, held level and one-cycle key strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [2:0]    rs_meta;
  logic [2:0]    rs;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [1:0]    col_nx;
  logic [1:0]    row_pick;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] stb_cnt;
  logic          row_low;
  logic          any_low;
  logic          sample;
  logic          stb_last;
  logic          accept;
  logic          fresh;
  logic          held;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_meta <= 3'b111;
      rs      <= 3'b111;
    end else begin
      rs_meta <= row_n;
      rs      <= rs_meta;
    end
  end

  assign any_low  = ~&rs;
  assign sample   = (div_cnt == DIV_LAST);
  assign stb_last = (stb_cnt == STB_LAST);

  // Several rows may be low at once; the lowest index wins.
  always_comb begin
    row_pick = 2'd2;
    priority case (1'b1)
      !rs[0]:  row_pick = 2'd0;
      !rs[1]:  row_pick = 2'd1;
      default: row_pick = 2'd2;
    endcase
  end

  always_comb begin
    row_low = 1'b0;
    unique case (row)
      2'd0:    row_low = ~rs[0];
      2'd1:    row_low = ~rs[1];
      default: row_low = ~rs[2];
    endcase
  end

  always_comb begin
    col_nx = 2'd0;
    unique case (col)
      2'd0:    col_nx = 2'd1;
      2'd1:    col_nx = 2'd2;
      default: col_nx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      SCAN: begin
        if (sample && any_low) begin
          nstate = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          nstate = SCAN;
        end else if (stb_last) begin
          nstate = HELD;
        end
      end
      HELD: begin
        if (!row_low) begin
          nstate = RELEASE;
        end
      end
      RELEASE: begin
        if (row_low) begin
          nstate = HELD;
        end else if (stb_last) begin
          nstate = SCAN;
        end
      end
      default: nstate = SCAN;
    endcase
  end

  assign accept = (state == DEBOUNCE) && row_low && stb_last;

  // Column and row stay frozen from capture until the key is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      stb_cnt <= '0;
      col     <= 2'd0;
      row     <= 2'd0;
      fresh   <= 1'b0;
    end else begin
      fresh <= accept;
      unique case (state)
        SCAN: begin
          stb_cnt <= '0;
          if (sample) begin
            div_cnt <= '0;
            if (any_low) begin
              row <= row_pick;
            end else begin
              col <= col_nx;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            col     <= col_nx;
            div_cnt <= '0;
            stb_cnt <= '0;
          end else if (stb_last) begin
            stb_cnt <= '0;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        HELD: begin
          stb_cnt <= '0;
        end
        RELEASE: begin
          if (row_low) begin
            stb_cnt <= '0;
          end else if (stb_last) begin
            stb_cnt <= '0;
            div_cnt <= '0;
            col     <= col_nx;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        default: begin
          stb_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    col_n = 3'b110;
    unique case (col)
      2'd0:    col_n = 3'b110;
      2'd1:    col_n = 3'b101;
      default: col_n = 3'b011;
    endcase
    held      = (state == HELD) || (state == RELEASE);
    key_held  = held;
    key_valid = fresh;
    key       = held ? {col, row} : 4'b1111;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios checked every cycle
// against a cycle-level behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DB = 16;
  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [8:0] keys = '0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit armed = 1'b0;

  int         m_mode = M_SCAN;
  int         m_col = 0;
  int         m_row = 0;
  int         m_dwell = 0;
  int         m_run = 0;
  logic [2:0] m_s1 = 3'b111;
  logic [2:0] m_s2 = 3'b111;
  logic [3:0] m_key = 4'hf;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Physical matrix: a pressed key shorts its row to its driven column.
  always_comb begin
    row_n = 3'b111;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (keys[c*3+r] && col_n[c] === 1'b0) row_n[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] now;
    int nr;
    now = 3'b111;
    for (int r = 0; r < 3; r++) begin
      if (keys[m_col*3+r]) now[r] = 1'b0;
    end
    m_valid = 1'b0;
    if (reset) begin
      m_mode = M_SCAN; m_col = 0; m_row = 0;
      m_dwell = 0; m_run = 0;
      m_s1 = 3'b111; m_s2 = 3'b111;
      m_key = 4'hf; m_held = 1'b0;
      armed = 1'b1;
      return;
    end
    case (m_mode)
      M_SCAN: begin
        if (m_dwell < SD - 1) begin
          m_dwell++;
        end else begin
          m_dwell = 0;
          if (m_s2 != 3'b111) begin
            nr = 0;
            while (m_s2[nr]) nr++;
            m_row = nr; m_run = 0; m_mode = M_DEB;
          end else begin
            m_col = (m_col + 1) % 3;
          end
        end
      end
      M_DEB: begin
        if (m_s2[m_row]) begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 3;
          m_dwell = 0; m_run = 0;
        end else if (m_run == DB - 1) begin
          m_mode = M_HELD; m_valid = 1'b1; m_held = 1'b1;
          m_key = 4'(m_col * 4 + m_row);
        end else begin
          m_run++;
        end
      end
      M_HELD: begin
        if (m_s2[m_row]) begin
          m_mode = M_REL; m_run = 0;
        end
      end
      default: begin
        if (!m_s2[m_row]) begin
          m_mode = M_HELD;
        end else if (m_run == DB - 1) begin
          m_mode = M_SCAN; m_key = 4'hf; m_held = 1'b0;
          m_col = (m_col + 1) % 3; m_dwell = 0;
        end else begin
          m_run++;
        end
      end
    endcase
    m_s2 = m_s1;
    m_s1 = now;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [2:0] ecol;
    @(negedge clk);
    if (armed) begin
      ecol = 3'b111;
      ecol[m_col] = 1'b0;
      chk("col_n", 32'(col_n), 32'(ecol));
      chk("key", 32'(key), 32'(m_key));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("key_held", 32'(key_held), 32'(m_held));
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name);
    int p0;
    bit ok;
    p0 = pulses;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      tick();
      if (pulses != p0) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 400 && key_held !== 1'b0; t++) tick();
    chk(name, 32'(key_held), 32'd0);
  endtask

  task automatic wait_deb(input string name);
    for (int t = 0; t < 400 && m_mode != M_DEB; t++) tick();
    chk(name, 32'(m_mode), 32'(M_DEB));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " col_n"}, 32'(col_n), 32'h6);
    chk({tag, " key"}, 32'(key), 32'hf);
    chk({tag, " key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, " key_held"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    int p0;
    logic [2:0] ec;
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      ec = (i < 8) ? 3'b110 : (i < 16) ? 3'b101 : 3'b011;
      chk("scan order", 32'(col_n), 32'(ec));
      tick();
    end
    chk("idle pulses", 32'(pulses), 32'd0);

    keys[3] = 1'b1;
    wait_pulse("c1r0 pulse");
    chk("c1r0 key", 32'(key), 32'h4);
    chk("c1r0 held", 32'(key_held), 32'd1);
    chk("c1r0 decode", 32'(key[3:2]) + 32'd3 * 32'(key[1:0]), 32'd1);
    chk("c1r0 count", 32'(pulses), 32'd1);
    keys = '0;
    wait_idle("c1r0 release");
    chk("c1r0 key after", 32'(key), 32'hf);

    p0 = pulses;
    keys[7] = 1'b1;
    wait_deb("short deb");
    repeat (10) tick();
    keys = '0;
    repeat (40) tick();
    chk("short no pulse", 32'(pulses), 32'(p0));
    chk("short key", 32'(key), 32'hf);
    chk("short held", 32'(key_held), 32'd0);

    keys[7] = 1'b1;
    wait_deb("long deb");
    repeat (20) tick();
    keys = '0;
    chk("long pulse", 32'(pulses), 32'(p0 + 1));
    chk("long key", 32'(key), 32'h9);
    wait_idle("long release");
    chk("long key after", 32'(key), 32'hf);

    p0 = pulses;
    keys[2] = 1'b1;
    wait_pulse("bounce pulse");
    chk("bounce key", 32'(key), 32'h2);
    keys = '0;
    repeat (5) tick();
    keys[2] = 1'b1;
    repeat (10) tick();
    chk("bounce still held", 32'(key_held), 32'd1);
    keys = '0;
    repeat (20) tick();
    wait_idle("bounce release");
    chk("bounce single", 32'(pulses), 32'(p0 + 1));
    chk("bounce key after", 32'(key), 32'hf);

    keys[0] = 1'b1;
    keys[2] = 1'b1;
    wait_pulse("multi pulse");
    chk("multi key", 32'(key), 32'h0);
    p0 = pulses;
    keys[4] = 1'b1;
    repeat (40) tick();
    chk("ignore pulses", 32'(pulses), 32'(p0));
    chk("ignore key", 32'(key), 32'h0);
    chk("ignore col", 32'(col_n), 32'h6);
    keys = '0;
    wait_idle("multi release");

    keys[6] = 1'b1;
    wait_pulse("c2r0 pulse");
    chk("c2r0 key", 32'(key), 32'h8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("midheld");
    reset = 1'b0;
    p0 = pulses;
    wait_pulse("redetect pulse");
    chk("redetect key", 32'(key), 32'h8);
    chk("redetect count", 32'(pulses), 32'(p0 + 1));
    keys = '0;
    wait_idle("final release");
    chk("final key", 32'(key), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
